// File: rtl/accu_decim_pkg.sv
// accu_decim_pkg: shared helpers for the decimating averager and other rate-change stages
package accu_decim_pkg;

    // Right-shift needed to bring a SW-bit window sum down to the output width.
    function automatic int calc_shift(int in_w, int log2_n, int out_w);
        return in_w + log2_n - out_w;
    endfunction

    // Round half toward +inf by sh bits, then clamp to a signed out_w-bit range.
    function automatic longint round_sat(longint v, int sh, int out_w);
        longint r;
        longint hi;
        longint lo;
        r  = (v + (longint'(1) <<< (sh - 1))) >>> sh;
        hi = (longint'(1) <<< (out_w - 1)) - 1;
        lo = -(longint'(1) <<< (out_w - 1));
        return (r > hi) ? hi : ((r < lo) ? lo : r);
    endfunction

endpackage

// File: rtl/accu_decim_fifo.sv
// accu_decim_fifo: 2-entry valid/ready FIFO with a registered head that holds its last value when empty
module accu_decim_fifo #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_valid,
    output logic         o_full
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic         r_hv;
    logic         r_tv;
    logic         w_pop;

    assign w_pop   = r_hv & i_pop;
    assign o_dout  = r_head;
    assign o_valid = r_hv;
    assign o_full  = r_tv;

    // Head/tail slots; a push into a full buffer with no pop is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_hv   <= 1'b0;
            r_tv   <= 1'b0;
        end else if (w_pop) begin
            if (r_tv) begin
                r_head <= r_tail;
                r_tv   <= i_push;
                if (i_push) r_tail <= i_din;
            end else begin
                r_hv <= i_push;
                if (i_push) r_head <= i_din;
            end
        end else if (i_push) begin
            if (!r_hv) begin
                r_head <= i_din;
                r_hv   <= 1'b1;
            end else if (!r_tv) begin
                r_tail <= i_din;
                r_tv   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/accu_decim.sv
// accu_decim: boxcar averager summing 2^LOG2_N enabled samples, rounding/saturating into a 2-entry output buffer
module accu_decim
    import accu_decim_pkg::*;
#(
    parameter int IN_WIDTH  = 26,
    parameter int OUT_WIDTH = 16,
    parameter int LOG2_N    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        EN,
    input  logic signed [IN_WIDTH-1:0]  IN,
    output logic signed [OUT_WIDTH-1:0] OUT,
    output logic                        OUT_VALID,
    input  logic                        OUT_READY,
    output logic                        OVF
);

    localparam int SW    = IN_WIDTH + LOG2_N;
    localparam int SHIFT = calc_shift(IN_WIDTH, LOG2_N, OUT_WIDTH);

    if (SHIFT < 1) begin : g_bad_shift
        $error("accu_decim: SHIFT must be >= 1");
    end

    logic signed [SW-1:0]        r_sum;
    logic signed [SW-1:0]        w_total;
    logic        [LOG2_N-1:0]    r_cnt;
    logic                        w_last;
    logic                        w_full;
    logic                        r_ovf;
    logic signed [OUT_WIDTH-1:0] w_res;

    assign w_total = r_sum + SW'(IN);
    assign w_last  = EN & (&r_cnt);
    assign w_res   = OUT_WIDTH'(round_sat(longint'(w_total), SHIFT, OUT_WIDTH));
    assign OVF     = r_ovf;

    // Window accumulation; the counter wraps to 0 on the last sample and the sum restarts empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
            r_cnt <= '0;
        end else if (EN) begin
            r_cnt <= r_cnt + LOG2_N'(1);
            r_sum <= w_last ? '0 : w_total;
        end
    end

    // Sticky drop flag: a finished window arrived while the buffer was full and not draining.
    always_ff @(posedge clk) begin
        if (rst) r_ovf <= 1'b0;
        else     r_ovf <= r_ovf | (w_last & w_full & ~(OUT_VALID & OUT_READY));
    end

    accu_decim_fifo #(.W(OUT_WIDTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_last),
        .i_din   (w_res),
        .i_pop   (OUT_READY),
        .o_dout  (OUT),
        .o_valid (OUT_VALID),
        .o_full  (w_full)
    );

endmodule

// File: tb/tb_accu_decim.sv
// tb_accu_decim: directed test-plan cases plus random traffic checked against a queue-based reference model
module tb_accu_decim;

    logic               clk = 1'b0;
    logic               rst;
    logic               EN;
    logic signed [25:0] IN;
    logic signed [15:0] OUT;
    logic               OUT_VALID;
    logic               OUT_READY;
    logic               OVF;

    int n_chk  = 0;
    int n_pass = 0;

    longint win_sum;
    int     win_cnt;
    longint mq[$];
    longint m_out;
    bit     m_ovf;

    always #5 clk = ~clk;

    accu_decim dut (
        .clk       (clk),
        .rst       (rst),
        .EN        (EN),
        .IN        (IN),
        .OUT       (OUT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OVF       (OVF)
    );

    task automatic chk(string tag, longint got, longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic longint floor_div(longint a, longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint avg_result(longint total);
        longint r;
        r = floor_div(total + 8192, 16384);
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic model_edge(bit r, bit en, longint v, bit rdy);
        bit     pop;
        bit     push;
        longint res;
        if (r) begin
            win_sum = 0;
            win_cnt = 0;
            mq.delete();
            m_out = 0;
            m_ovf = 0;
            return;
        end
        pop  = (mq.size() > 0) && rdy;
        push = 0;
        res  = 0;
        if (en) begin
            win_sum += v;
            win_cnt++;
            if (win_cnt == 16) begin
                res     = avg_result(win_sum);
                push    = 1;
                win_sum = 0;
                win_cnt = 0;
            end
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() == 2) m_ovf = 1;
            else mq.push_back(res);
        end
        if (mq.size() > 0) m_out = mq[0];
    endtask

    task automatic step(bit r, bit en, longint v, bit rdy);
        rst       = r;
        EN        = en;
        IN        = v[25:0];
        OUT_READY = rdy;
        @(posedge clk);
        #1;
        model_edge(r, en, v, rdy);
        chk("valid", longint'(OUT_VALID), longint'(mq.size() > 0));
        chk("out", longint'(OUT), m_out);
        chk("ovf", longint'(OVF), longint'(m_ovf));
    endtask

    task automatic window(longint v, bit rdy, bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps) step(0, 0, 33554431, rdy);
            step(0, 1, v, rdy);
        end
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_out", longint'(OUT), 0);
        chk("rst_valid", longint'(OUT_VALID), 0);
        chk("rst_ovf", longint'(OVF), 0);
    endtask

    task automatic expect_head(string tag, longint v);
        chk({tag, "_v"}, longint'(OUT_VALID), 1);
        chk(tag, longint'(OUT), v);
    endtask

    initial begin
        rst = 1'b1; EN = 1'b0; IN = '0; OUT_READY = 1'b0;
        win_sum = 0; win_cnt = 0; m_out = 0; m_ovf = 0;
        do_reset();

        window(16384, 1, 0);
        expect_head("rnd_pos", 16);
        step(0, 0, 0, 1);
        chk("pulse_len", longint'(OUT_VALID), 0);

        window(18849555, 1, 0);
        expect_head("lim_pos", 18408);
        window(-18849555, 1, 0);
        expect_head("lim_neg", -18408);
        window(33554431, 1, 0);
        expect_head("sat_pos", 32767);
        window(-33554432, 1, 0);
        expect_head("sat_neg", -32768);
        window(16384, 1, 1);
        expect_head("gaps", 16);
        step(0, 0, 0, 1);

        window(16384, 0, 0);
        window(32768, 0, 0);
        window(49152, 0, 0);
        expect_head("bp_first", 16);
        chk("bp_ovf", longint'(OVF), 1);
        step(0, 0, 0, 1);
        expect_head("bp_second", 32);
        step(0, 0, 0, 1);
        chk("bp_empty", longint'(OUT_VALID), 0);
        chk("bp_hold", longint'(OUT), 32);

        for (int i = 0; i < 7; i++) step(0, 1, 33554431, 1);
        step(1, 1, 33554431, 1);
        chk("mid_rst_valid", longint'(OUT_VALID), 0);
        chk("mid_rst_ovf", longint'(OVF), 0);
        window(16384, 1, 0);
        expect_head("mid_rst", 16);

        for (int i = 0; i < 1500; i++) begin
            longint v;
            int     sel;
            sel = $urandom_range(0, 9);
            v   = longint'($signed(26'($urandom)));
            if (sel == 0) v = 33554431;
            if (sel == 1) v = -33554432;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8, v, $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/accu_decim.md
# accu_decim

Decimating boxcar averager placed directly downstream of the saturating 26-bit accumulator. It consumes the accumulator's per-cycle signed output and sums 2^LOG2_N enabled samples. Each completed window is rounded and saturated to OUT_WIDTH, then delivered through a 2-entry valid/ready output buffer to the slower-rate consumer.

## Interface
- IN_WIDTH, default 26: signed input width; matches the accumulator output width.
- OUT_WIDTH, default 16: signed output width.
- LOG2_N, default 4: log2 of the decimation factor (N = 16).
- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset, synchronous and active-high.
- EN, input, 1: sample qualifier; IN is consumed only on cycles with EN=1.
- IN, input, IN_WIDTH: signed sample; the accumulator output, sampled every enabled cycle.
- OUT, output, OUT_WIDTH: signed averaged result at the head of the buffer.
- OUT_VALID, output, 1: head entry is valid.
- OUT_READY, input, 1: consumer accepts the head entry when OUT_VALID & OUT_READY.
- OVF, output, 1: sticky flag; a window result was dropped because the buffer was full.

## Operation
- Internal sum width: SW = IN_WIDTH + LOG2_N, signed, so no wrap is possible.
- SHIFT = SW − OUT_WIDTH. SHIFT must be ≥ 1; with the defaults SHIFT = 14. Elaboration fails if SHIFT < 1.
- Window counter cnt runs 0..N−1 and advances only on EN=1.
  - EN=1 and cnt < N−1: sum ← sum + IN, and cnt increments.
  - EN=1 and cnt = N−1:
    - total = sum + IN
    - res = (total + 2^(SHIFT−1)) >>> SHIFT, i.e. round half toward +∞
    - res saturates to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1]
    - res is pushed to the buffer; sum ← 0 and cnt ← 0. The next window starts empty with no sample carry-over.
  - EN=0: sum and cnt hold.
- Output buffer: 2-entry FIFO, in-order delivery.
  - Pop on OUT_VALID & OUT_READY.
  - Push when full with no pop in the same cycle: the new result is dropped, buffer contents are unchanged, and OVF ← 1.
  - Push when full with a pop in the same cycle: both occur and nothing is lost.
  - Push into empty: the entry appears at the head.
- OVF clears only on rst.
- OUT holds the head entry when OUT_VALID=1. It is held at its last value (0 after reset) when the buffer is empty.

## Timing
- Reset values: OUT = 0, OUT_VALID = 0, OVF = 0, sum = 0, cnt = 0, buffer empty.
- Latency: the result of a window whose last sample is taken in cycle t has OUT_VALID = 1 in cycle t+1. The path is one register stage into the buffer; there is no extra bypass.
- With OUT_READY held high, one result is delivered per window, and OUT_VALID is high for exactly one cycle per window when EN=1 continuously.
- OUT and OUT_VALID must not depend combinationally on OUT_READY; both are driven straight from registers.
- rst mid-window or with a full buffer: all partial sums and buffered results are discarded, and all outputs return to their reset values in the next cycle.
- rst dominates a coincident push or pop.

## Structure
- Shared package holds:
  - A function computing SHIFT from (IN_WIDTH, LOG2_N, OUT_WIDTH).
  - A saturating round-and-shift function, reusable by other rate-change stages.
- Sub-module accu_decim_fifo: parameterised 2-entry valid/ready FIFO with full/empty flags and push/pop. It is instantiated once.
- The top level contains the counter, the summer and the round/saturate logic.

## Test plan
- Rounding, positive:
  - IN = 16384, EN = 1 for 16 cycles, OUT_READY = 1.
  - Required: one pulse with OUT = 16, one cycle after the 16th sample.
- Limit value:
  - IN = 301592880/16 = 18849555 for 16 cycles → OUT = 18408.
  - IN = −18849555 for 16 cycles → OUT = −18408.
- Saturation:
  - IN = 33554431 for 16 cycles → OUT = 32767.
  - IN = −33554432 for 16 cycles → OUT = −32768.
- EN gaps:
  - 16 samples of IN = 16384, interleaved with EN = 0 cycles carrying IN = 33554431.
  - Required: OUT = 16; the gap samples are ignored.
- Backpressure and overflow:
  - OUT_READY = 0 for 3 windows of constant values 1×, 2× and 3× 16384.
  - Required: OUT_VALID = 1, OVF = 1 after the third window.
  - Then OUT_READY = 1: outputs are 16, then 32, and the 48 result is dropped.
- Reset mid-window:
  - Assert rst after 7 samples, then send 16 samples of IN = 16384.
  - Required: OUT = 16 with no contamination from the earlier samples; OVF = 0 and OUT_VALID = 0 during reset.
